// File: rtl/egress_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : egress_drain_pkg
//  Description : Shared constants for the egress drain block. Holds the word
//                width, the dest/class field positions inside a switch word,
//                the drain FSM state encodings and a one-hot helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package egress_drain_pkg;

    // Switch word layout: [11:10] class, [9:8] destination port, [7:0] payload
    localparam int TAMANO_DATOS = 12;
    localparam int DEST_MSB     = 9;
    localparam int DEST_LSB     = 8;
    localparam int CLASS_MSB    = 11;
    localparam int CLASS_LSB    = 10;

    // Drain FSM encodings
    localparam int                 STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_POP  = 2'd1;
    localparam logic [STATE_W-1:0] ST_WAIT = 2'd2;
    localparam logic [STATE_W-1:0] ST_HOLD = 2'd3;

    // Port index to one-hot FIFO read enable
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/egress_drain_rr_select4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_select4
//  Description : Combinational 4-way round-robin picker. Searches the request
//                vector starting just after the last served port and wrapping
//                around, so the last served port has the lowest priority.
//  Ports       : i_req        - request per port (bit n = port n)
//                i_last_grant - port served most recently
//                o_grant      - selected port (only meaningful if o_any_req)
//                o_any_req    - at least one request is present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_select4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_last_grant,
    output logic [1:0] o_grant,
    output logic       o_any_req
);

    // Candidate k is the (k+1)-th port after the last grant; the 2-bit add
    // wraps naturally, so candidate 3 is the last grant itself.
    logic [1:0] w_cand [4];

    for (genvar g = 0; g < 4; g++) begin : g_cand
        assign w_cand[g] = i_last_grant + 2'(g + 1);
    end

    // Walk from lowest to highest priority so the first requester found in
    // search order is the one that survives.
    always_comb begin
        o_grant = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (i_req[w_cand[k]]) begin
                o_grant = w_cand[k];
            end
        end
    end

    assign o_any_req = |i_req;

endmodule
`default_nettype wire

// File: rtl/egress_drain.sv
`default_nettype none
// ============================================================================
//  Module      : egress_drain
//  Description : Drains the four egress FIFOs of the switch in round-robin
//                order and presents each word on one valid/ready stream tagged
//                with its source port. Keeps a delivered-word counter per port
//                and a sticky flag for words whose dest field disagrees with
//                the FIFO they were read from.
//  Ports       : clk, reset           - clock, synchronous active-high reset
//                enable               - allows new drains (sampled in IDLE)
//                empty[3:0]           - egress FIFO empty flags
//                data_in0..data_in3   - egress FIFO read data
//                pop[3:0]             - one-hot FIFO read enable (registered)
//                out_valid/out_ready  - output handshake
//                out_data, out_port   - drained word and its source port
//                cnt_idx, cnt_data    - counter read port (combinational)
//                route_err            - sticky dest/source mismatch flag
//                busy                 - a drain is in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module egress_drain #(
    parameter int TAMANO_DATOS = egress_drain_pkg::TAMANO_DATOS,
    parameter int CONT_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [3:0]              empty,
    input  logic [TAMANO_DATOS-1:0] data_in0,
    input  logic [TAMANO_DATOS-1:0] data_in1,
    input  logic [TAMANO_DATOS-1:0] data_in2,
    input  logic [TAMANO_DATOS-1:0] data_in3,
    output logic [3:0]              pop,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [TAMANO_DATOS-1:0] out_data,
    output logic [1:0]              out_port,
    input  logic [1:0]              cnt_idx,
    output logic [CONT_WIDTH-1:0]   cnt_data,
    output logic                    route_err,
    output logic                    busy
);

    import egress_drain_pkg::*;

    logic [STATE_W-1:0]      r_state;
    logic [1:0]              r_grant;
    logic [1:0]              r_last_grant;
    logic [3:0]              r_pop;
    logic                    r_out_valid;
    logic [TAMANO_DATOS-1:0] r_out_data;
    logic [1:0]              r_out_port;
    logic                    r_route_err;
    logic [CONT_WIDTH-1:0]   r_cnt [4];

    logic [1:0]              w_grant;
    logic                    w_any_req;
    logic [TAMANO_DATOS-1:0] w_sel_data;
    logic                    w_dest_bad;

    rr_select4 u_rr (
        .i_req        (~empty),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_any_req    (w_any_req)
    );

    // Read data of the granted FIFO; only sampled in WAIT, one cycle after
    // the pop, when the FIFO output reflects the popped word.
    always_comb begin
        w_sel_data = data_in0;
        case (r_grant)
            2'd0:    w_sel_data = data_in0;
            2'd1:    w_sel_data = data_in1;
            2'd2:    w_sel_data = data_in2;
            default: w_sel_data = data_in3;
        endcase
    end

    assign w_dest_bad = (w_sel_data[DEST_MSB:DEST_LSB] != r_grant);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= 2'd0;
            r_last_grant <= 2'd3;       // port 0 is first in search order
            r_pop        <= 4'b0000;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_port   <= 2'd0;
            r_route_err  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable && w_any_req) begin
                        r_grant <= w_grant;
                        r_pop   <= onehot4(w_grant);
                        r_state <= ST_POP;
                    end
                end
                ST_POP: begin
                    // Single-cycle read enable: only one pop is ever in flight
                    r_pop   <= 4'b0000;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_out_data  <= w_sel_data;
                    r_out_port  <= r_grant;
                    r_out_valid <= 1'b1;
                    if (w_dest_bad) begin
                        r_route_err <= 1'b1;
                    end
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid    <= 1'b0;
                        r_cnt[r_grant] <= r_cnt[r_grant] + CONT_WIDTH'(1);
                        r_last_grant   <= r_grant;
                        r_state        <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pop       = r_pop;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_port  = r_out_port;
    assign route_err = r_route_err;
    assign busy      = (r_state != ST_IDLE);
    assign cnt_data  = r_cnt[cnt_idx];

endmodule
`default_nettype wire

// File: doc/egress_drain.md
Name: egress_drain

Overview:
- Downstream consumer of the PCIE switch's four egress FIFOs (fifo4..fifo7).
- Generates the per-FIFO pops that the probador drives today.
- Drains non-empty egress FIFOs in round-robin order and presents each word on a single valid/ready output stream, tagged with its source port.
- Keeps per-port delivered-word counters and a sticky routing-error flag: the word's dest field disagrees with the FIFO it came from.

Parameters:
TAMANO_DATOS, 12, word width; dest field is bits [9:8], class bits [11:10].
CONT_WIDTH, 8, width of each per-port delivered-word counter.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  permits starting new drains; sampled only in IDLE.
empty  input  4  empty flags of egress FIFOs, bit n = port n.
data_in0  input  TAMANO_DATOS  data_out of egress FIFO port 0.
data_in1  input  TAMANO_DATOS  data_out of egress FIFO port 1.
data_in2  input  TAMANO_DATOS  data_out of egress FIFO port 2.
data_in3  input  TAMANO_DATOS  data_out of egress FIFO port 3.
pop  output  4  registered one-hot read_enable to egress FIFOs.
out_valid  output  1  out_data/out_port hold a word.
out_ready  input  1  sink accepts word when out_valid & out_ready.
out_data  output  TAMANO_DATOS  drained word.
out_port  output  2  source port of out_data.
cnt_idx  input  2  selects counter for cnt_data.
cnt_data  output  CONT_WIDTH  combinational read of counter[cnt_idx].
route_err  output  1  sticky: a drained word had data[9:8] != source port.
busy  output  1  state != IDLE.

Behaviour:
- Interface is fixed: one clock, clk; reset is synchronous and active-high, port reset.
- Reset values:
  - Outputs: pop=0, out_valid=0, out_data=0, out_port=0, route_err=0, busy=0.
  - Internal: all counters=0; state=IDLE; last_grant=3, so port 0 is served first.
- Egress FIFO read timing: data_out is valid on the cycle after read_enable is sampled high.
- FSM states:
  - IDLE: if enable && empty!=4'hF, set grant = first non-empty port searching last_grant+1, +2, +3, +4 (mod 4), then go to POP. Otherwise stay.
  - POP: pop = one-hot(grant) for exactly this one cycle, then go to WAIT.
  - WAIT: pop=0. At the end of the cycle, register out_data=data_in[grant], out_port=grant, out_valid=1. If data_in[grant][9:8]!=grant, set route_err. Go to HOLD.
  - HOLD: out_valid, out_data and out_port stay stable until out_valid && out_ready. On that edge: out_valid=0, counter[grant]++, last_grant=grant, go to IDLE.
- Latency and throughput:
  - Minimum 3 cycles from leaving IDLE to out_valid.
  - At most one word per 4 cycles.
  - Only one pop is ever outstanding, so an egress FIFO is never over-read.
- empty is sampled only in IDLE. By then, the FIFO's empty update from the previous pop (1 cycle) has settled.
- Boundary conditions:
  - enable deasserted mid-transaction: the transaction completes; no new drain starts.
  - out_ready held low: stay in HOLD indefinitely; pop stays 0.
  - Single non-empty port: it is served repeatedly.
  - All four ports non-empty: grant order is 0,1,2,3,0,...
  - Counter at 2^CONT_WIDTH-1: wraps to 0; no saturation.
  - route_err: cleared only by reset.
  - reset in any state: next cycle, all outputs and registers take their reset values. A pop already issued is lost (the FIFOs reset as well).
  - out_ready high outside HOLD: ignored.

Decomposition:
- Shared package holds:
  - TAMANO_DATOS and the field positions DEST_MSB=9, DEST_LSB=8, CLASS_MSB=11, CLASS_LSB=10.
  - State encodings IDLE=2'd0, POP=2'd1, WAIT=2'd2, HOLD=2'd3.
- One natural sub-module: rr_select4 (combinational). Inputs: 4-bit request (~empty) and 2-bit last_grant. Outputs: 2-bit grant and any_req.
- Counters, FSM and output register stay in egress_drain.

Test Plan:
- Reset sequence: hold reset 2 cycles with empty=4'h0, enable=1.
  - During reset: pop=0, out_valid=0.
  - First pop after release: 4'b0001.
- Single port: empty=4'b1011 (port 2 has 3 words 0x2A5,0x2A6,0x2A7, dest=2), out_ready=1.
  - pop=4'b0100 three times, 4 cycles apart.
  - out_data sequence 0x2A5,0x2A6,0x2A7, out_port=2.
  - counter[2]=3; route_err=0.
- Round robin: one word in every port, out_ready=1.
  - pops in order 0001,0010,0100,1000.
  - counters 1,1,1,1.
- Backpressure: out_ready=0 for 10 cycles after out_valid.
  - out_data stable; no further pop; counter unchanged until ready=1.
- Routing error: port 1 supplies 0x300 (dest=3) → route_err=1 after WAIT, still 1 after later good words.
- Wrap and reset: 256 words through port 0 → counter[0]=0. Assert reset while in HOLD → out_valid=0 and state=IDLE on next cycle.
